sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 16x8 FIFO.
//  Generalises width and depth, including non-power-of-2 depth.
//  Adds configurable almost-full/almost-empty levels, an occupancy count and optional storage parity.
//  Sits between a producer/consumer pair on one clock domain.
// PARAMETERS
//  FIFO_WIDTH  16          data word width in bits (>=1)
//  FIFO_DEPTH  8           number of entries (>=2, need not be a power of 2)
//  AF_LEVEL    FIFO_DEPTH-1  almostfull asserted when count >= AF_LEVEL (1..FIFO_DEPTH-1)
//  AE_LEVEL    1           almostempty asserted when count <= AE_LEVEL (0..FIFO_DEPTH-2)
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               synchronous reset, active-high
//  data_in      in   FIFO_WIDTH      write data
//  wr_en        in   1               write request
//  rd_en        in   1               read request
//  data_out     out  FIFO_WIDTH      read data (registered)
//  wr_ack       out  1               previous-cycle write accepted
//  overflow     out  1               previous-cycle write rejected (full)
//  underflow    out  1               previous-cycle read rejected (empty)
//  full         out  1               count == FIFO_DEPTH
//  empty        out  1               count == 0
//  almostfull   out  1               count >= AF_LEVEL
//  almostempty  out  1               count <= AE_LEVEL
//  count        out  CW              occupancy; CW = $clog2(FIFO_DEPTH+1)
//  parity_err   out  1               only with SYNC_FIFO_PARITY_EN; see CONFIGURATION
// BEHAVIOUR
//  - All state updates on rising clk edge. rst has priority over wr_en/rd_en.
//  - Reset values: pointers=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0,
//    parity_err=0. Flags: empty=1, almostempty=1, full=0, almostfull=0.
//  - Reset mid-operation discards all contents. Memory array is not cleared.
//  - Write accepted: wr_en && (!full || rd_en). Word stored at wr_ptr; wr_ptr advances.
//  - Read accepted: rd_en && !empty. mem[rd_ptr] registered into data_out (1-cycle latency); rd_ptr advances.
//  - When no read is accepted, data_out holds its value.
//  - Full, wr_en+rd_en: both accepted, count unchanged, overflow=0.
//  - Empty, wr_en+rd_en: write accepted, read rejected, underflow=1, count+1.
//  - wr_ack/overflow/underflow are registered, valid the cycle after the request.
//  - Each of these is a one-cycle pulse per offending or accepted request.
//  - Pointers wrap FIFO_DEPTH-1 -> 0 (explicit compare, not bit truncation).
//  - count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
//  - count never exceeds FIFO_DEPTH and never goes below 0.
//  - Status flags are combinational decodes of count, with no extra latency.
//  - Flags may overlap (e.g. empty && almostempty).
//  - No FSM beyond pointer/count state. The block must not stall: rd/wr are sampled every cycle.
// CONFIGURATION
//  SYNC_FIFO_PARITY_EN defined:
//  - Memory is FIFO_WIDTH+1 wide and stores the even parity (^data_in) with each word.
//  - On an accepted read, parity_err <= (^stored_word != stored_parity), registered alongside data_out.
//  - parity_err holds until the next accepted read or rst.
//  SYNC_FIFO_PARITY_EN undefined:
//  - Memory is FIFO_WIDTH wide and the parity_err port is absent.
//  - All other behaviour is identical.
// TESTING
//  1. rst=1 two cycles -> empty=1, almostempty=1, full=0, count=0, data_out=0, all pulses 0.
//  2. DEPTH=8: write 0x0001..0x0008 -> full=1, count=8.
//     9th write -> overflow=1 next cycle, wr_ack=0, count=8.
//  3. Read 8 from full -> data_out 0x0001..0x0008 in order, each one cycle after rd_en.
//     Extra read -> underflow=1, data_out holds 0x0008.
//  4. Full, wr_en=rd_en=1 -> wr_ack=1, overflow=0, count=8.
//     Empty, both -> underflow=1, wr_ack=1, count=1.
//  5. FIFO_DEPTH=5: 12 write/read pairs -> wrap correct, order preserved, count in 0..5.
//     Check almostfull at count 4, almostempty at count <=1.
//  6. Reset at count=3 -> next cycle count=0, empty=1.
//     SYNC_FIFO_PARITY_EN: force a stored bit flip -> parity_err=1 with that word's data_out.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with parametrised width and depth. The depth does not
//   have to be a power of two. Also provides almost-full and almost-empty
//   levels, an occupancy count, and optional parity on the stored words.
//
// Optional feature macro: SYNC_FIFO_PARITY_EN
//   When defined, each stored word carries an even-parity bit. The port
//   parity_err reports a parity mismatch on the last accepted read.
//   When undefined, the memory holds only the data and parity_err is absent.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high; wins over wr_en/rd_en
//   data_in      in   [FIFO_WIDTH-1:0] write data
//   wr_en        in   write request
//   rd_en        in   read request
//   data_out     out  [FIFO_WIDTH-1:0] read data, registered, 1-cycle latency
//   wr_ack       out  pulse: write in the previous cycle was accepted
//   overflow     out  pulse: write in the previous cycle was rejected (full)
//   underflow    out  pulse: read in the previous cycle was rejected (empty)
//   full         out  count == FIFO_DEPTH
//   empty        out  count == 0
//   almostfull   out  count >= AF_LEVEL
//   almostempty  out  count <= AE_LEVEL
//   count        out  [CW-1:0] occupancy, CW = $clog2(FIFO_DEPTH+1)
//   parity_err   out  (SYNC_FIFO_PARITY_EN only) parity mismatch on last read

module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
`ifdef SYNC_FIFO_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  // Pointer width covers indices 0..FIFO_DEPTH-1.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef SYNC_FIFO_PARITY_EN
  localparam int MW = FIFO_WIDTH + 1;
`else
  localparam int MW = FIFO_WIDTH;
`endif

  // Compare constants are sized to the count and pointer widths so that
  // the flag decodes compare operands of equal width.
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Storage. This memory is never reset; only the pointers and the count are.
  logic [MW-1:0] mem_reg [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic [FIFO_WIDTH-1:0] data_out_reg;
  logic                  wr_ack_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic          wr_accept;
  logic          rd_accept;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;

  // Status flags come directly from the registered count, so they change
  // in the same cycle as count.
  always_comb begin
    full        = (count_reg == DEPTH_CNT);
    empty       = (count_reg == CNT_ZERO);
    almostfull  = (count_reg >= AF_CNT);
    almostempty = (count_reg <= AE_CNT);
  end

  // When the FIFO is full, a write is still accepted if a read happens in
  // the same cycle. That read frees a slot because a full FIFO is never
  // empty. When the FIFO is empty, a read is rejected even if a write
  // happens in the same cycle. The written word becomes readable only in
  // the next cycle.
  always_comb begin
    wr_accept = wr_en && (!full || rd_en);
    rd_accept = rd_en && !empty;
  end

`ifdef SYNC_FIFO_PARITY_EN
  // Even parity: the stored bit equals the XOR of the data bits.
  always_comb wr_word = {^data_in, data_in};
`else
  always_comb wr_word = data_in;
`endif

  always_comb rd_word = mem_reg[rd_ptr_reg];

  // Pointers wrap by explicit compare, so depths that are not a power of
  // two work correctly.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (wr_accept) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_ONE;
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (rd_accept) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_ONE;
    end
  end

  // The count moves only when exactly one side is accepted. The accept
  // terms above keep it within 0..FIFO_DEPTH.
  always_comb begin
    count_next = count_reg;
    if (wr_accept && !rd_accept) begin
      count_next = count_reg + CNT_ONE;
    end else if (!wr_accept && rd_accept) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Memory write port. A reset cycle does not store anything.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_reg[wr_ptr_reg] <= wr_word;
    end
  end

  // Pointer, count and handshake-pulse state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      wr_ack_reg    <= wr_accept;
      overflow_reg  <= wr_en && !wr_accept;
      underflow_reg <= rd_en && !rd_accept;
    end
  end

  // Registered read data. It holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg <= '0;
    end else if (rd_accept) begin
      data_out_reg <= rd_word[FIFO_WIDTH-1:0];
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  logic parity_err_reg;

  // The parity check is registered together with data_out, so it always
  // describes the word currently shown on data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
    end else if (rd_accept) begin
      parity_err_reg <= (^rd_word[FIFO_WIDTH-1:0]) != rd_word[FIFO_WIDTH];
    end
  end

  always_comb parity_err = parity_err_reg;
`endif

  always_comb begin
    data_out  = data_out_reg;
    wr_ack    = wr_ack_reg;
    overflow  = overflow_reg;
    underflow = underflow_reg;
    count     = count_reg;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic clk;
  logic rst;

  // Instance A: default parameters (16 bits wide, depth 8, AF=7, AE=1).
  logic [15:0] a_data_in;
  logic        a_wr_en, a_rd_en;
  logic [15:0] a_data_out;
  logic        a_wr_ack, a_overflow, a_underflow;
  logic        a_full, a_empty, a_almostfull, a_almostempty;
  logic [3:0]  a_count;
`ifdef SYNC_FIFO_PARITY_EN
  logic        a_parity_err;
  logic        b_parity_err;
`endif

  // Instance B: depth 5 (not a power of two), AF=4, AE=1.
  logic [15:0] b_data_in;
  logic        b_wr_en, b_rd_en;
  logic [15:0] b_data_out;
  logic        b_wr_ack, b_overflow, b_underflow;
  logic        b_full, b_empty, b_almostfull, b_almostempty;
  logic [2:0]  b_count;

  int n_checks;
  int n_pass;

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data_in), .wr_en(a_wr_en), .rd_en(a_rd_en),
    .data_out(a_data_out), .wr_ack(a_wr_ack), .overflow(a_overflow),
    .underflow(a_underflow), .full(a_full), .empty(a_empty),
    .almostfull(a_almostfull), .almostempty(a_almostempty), .count(a_count)
`ifdef SYNC_FIFO_PARITY_EN
    , .parity_err(a_parity_err)
`endif
  );

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data_in), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .data_out(b_data_out), .wr_ack(b_wr_ack), .overflow(b_overflow),
    .underflow(b_underflow), .full(b_full), .empty(b_empty),
    .almostfull(b_almostfull), .almostempty(b_almostempty), .count(b_count)
`ifdef SYNC_FIFO_PARITY_EN
    , .parity_err(b_parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic wr, input logic rd, input logic [15:0] d);
    a_wr_en = wr;
    a_rd_en = rd;
    a_data_in = d;
  endtask

  task automatic b_drive(input logic wr, input logic rd, input logic [15:0] d);
    b_wr_en = wr;
    b_rd_en = rd;
    b_data_in = d;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    a_drive(1'b0, 1'b0, 16'h0);
    b_drive(1'b0, 1'b0, 16'h0);

    // 1. Reset held for two cycles.
    tick();
    tick();
    check("rst_empty", a_empty, 1);
    check("rst_aempty", a_almostempty, 1);
    check("rst_full", a_full, 0);
    check("rst_afull", a_almostfull, 0);
    check("rst_count", a_count, 0);
    check("rst_dout", a_data_out, 0);
    check("rst_wr_ack", a_wr_ack, 0);
    check("rst_ovf", a_overflow, 0);
    check("rst_udf", a_underflow, 0);
    check("rst_b_empty", b_empty, 1);
`ifdef SYNC_FIFO_PARITY_EN
    check("rst_perr", a_parity_err, 0);
`endif
    rst = 1'b0;

    // 2. Fill depth 8 with 0x0001..0x0008, then one write too many.
    for (int i = 1; i <= 8; i++) begin
      a_drive(1'b1, 1'b0, 16'(i));
      tick();
      check($sformatf("fill_ack_%0d", i), a_wr_ack, 1);
      check($sformatf("fill_cnt_%0d", i), a_count, i);
      check($sformatf("fill_afull_%0d", i), a_almostfull, (i >= 7) ? 1 : 0);
      check($sformatf("fill_aempty_%0d", i), a_almostempty, (i <= 1) ? 1 : 0);
    end
    check("fill_full", a_full, 1);
    a_drive(1'b1, 1'b0, 16'h0009);
    tick();
    check("ovf_pulse", a_overflow, 1);
    check("ovf_no_ack", a_wr_ack, 0);
    check("ovf_cnt", a_count, 8);
    a_drive(1'b0, 1'b0, 16'h0);
    tick();
    check("ovf_clear", a_overflow, 0);

    // 3. Drain in order, then one read too many.
    for (int i = 1; i <= 8; i++) begin
      a_drive(1'b0, 1'b1, 16'h0);
      tick();
      check($sformatf("drain_dout_%0d", i), a_data_out, i);
      check($sformatf("drain_cnt_%0d", i), a_count, 8 - i);
    end
    check("drain_empty", a_empty, 1);
    tick();
    check("udf_pulse", a_underflow, 1);
    check("udf_hold", a_data_out, 16'h0008);
    a_drive(1'b0, 1'b0, 16'h0);
    tick();
    check("udf_clear", a_underflow, 0);
    check("udf_hold2", a_data_out, 16'h0008);

    // 4a. Full with simultaneous write and read.
    for (int i = 0; i < 8; i++) begin
      a_drive(1'b1, 1'b0, 16'h0010 + 16'(i));
      tick();
    end
    check("sim_pre_full", a_full, 1);
    a_drive(1'b1, 1'b1, 16'h0018);
    tick();
    check("simf_ack", a_wr_ack, 1);
    check("simf_ovf", a_overflow, 0);
    check("simf_cnt", a_count, 8);
    check("simf_dout", a_data_out, 16'h0010);
    for (int i = 1; i <= 8; i++) begin
      a_drive(1'b0, 1'b1, 16'h0);
      tick();
      check($sformatf("simf_drain_%0d", i), a_data_out, 16'h0010 + 16'(i));
    end
    check("simf_empty", a_empty, 1);

    // 4b. Empty with simultaneous write and read.
    a_drive(1'b1, 1'b1, 16'h0020);
    tick();
    check("sime_udf", a_underflow, 1);
    check("sime_ack", a_wr_ack, 1);
    check("sime_cnt", a_count, 1);
    check("sime_dout_hold", a_data_out, 16'h0018);
    a_drive(1'b0, 1'b1, 16'h0);
    tick();
    check("sime_read", a_data_out, 16'h0020);
    check("sime_cnt0", a_count, 0);
    a_drive(1'b0, 1'b0, 16'h0);

    // 5. Depth 5: preload 1..4, then 12 write/read pairs, then drain.
    for (int i = 1; i <= 4; i++) begin
      b_drive(1'b1, 1'b0, 16'(i));
      tick();
      check($sformatf("b_pre_cnt_%0d", i), b_count, i);
      check($sformatf("b_pre_afull_%0d", i), b_almostfull, (i >= 4) ? 1 : 0);
      check($sformatf("b_pre_aempty_%0d", i), b_almostempty, (i <= 1) ? 1 : 0);
    end
    for (int k = 0; k < 12; k++) begin
      b_drive(1'b1, 1'b1, 16'h0100 + 16'(k));
      tick();
      check($sformatf("b_pair_dout_%0d", k), b_data_out,
            (k < 4) ? (k + 1) : (32'h0100 + k - 4));
      check($sformatf("b_pair_cnt_%0d", k), b_count, 4);
    end
    for (int k = 8; k < 12; k++) begin
      b_drive(1'b0, 1'b1, 16'h0);
      tick();
      check($sformatf("b_drain_%0d", k), b_data_out, 32'h0100 + k);
      check($sformatf("b_drain_aempty_%0d", k), b_almostempty, (k >= 10) ? 1 : 0);
    end
    check("b_empty", b_empty, 1);
    for (int i = 0; i < 5; i++) begin
      b_drive(1'b1, 1'b0, 16'h0200 + 16'(i));
      tick();
    end
    check("b_full", b_full, 1);
    check("b_full_cnt", b_count, 5);
    tick();
    check("b_ovf", b_overflow, 1);
    check("b_ovf_cnt", b_count, 5);
    b_drive(1'b0, 1'b1, 16'h0);
    tick();
    check("b_wrap_read", b_data_out, 16'h0200);
    b_drive(1'b0, 1'b0, 16'h0);

    // 6. Reset while holding three words.
    for (int i = 0; i < 3; i++) begin
      a_drive(1'b1, 1'b0, 16'h0021 + 16'(i));
      tick();
    end
    check("mid_cnt3", a_count, 3);
    a_drive(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cnt", a_count, 0);
    check("mid_rst_empty", a_empty, 1);
    check("mid_rst_dout", a_data_out, 0);
    a_drive(1'b1, 1'b0, 16'h0030);
    tick();
    a_drive(1'b0, 1'b1, 16'h0);
    tick();
    check("post_rst_read", a_data_out, 16'h0030);
    check("post_rst_cnt", a_count, 0);
    a_drive(1'b0, 1'b0, 16'h0);

`ifdef SYNC_FIFO_PARITY_EN
    // The next write goes to slot 1. Flip data bit 0 of that slot.
    a_drive(1'b1, 1'b0, 16'h0055);
    tick();
    a_drive(1'b0, 1'b0, 16'h0);
    dut_a.mem_reg[1] = dut_a.mem_reg[1] ^ 17'h00001;
    a_drive(1'b0, 1'b1, 16'h0);
    tick();
    check("perr_dout", a_data_out, 16'h0054);
    check("perr_set", a_parity_err, 1);
    a_drive(1'b0, 1'b0, 16'h0);
    tick();
    check("perr_hold", a_parity_err, 1);
    a_drive(1'b1, 1'b0, 16'h0007);
    tick();
    a_drive(1'b0, 1'b1, 16'h0);
    tick();
    check("perr_clean_dout", a_data_out, 16'h0007);
    check("perr_clear", a_parity_err, 0);
    a_drive(1'b0, 1'b0, 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
